// File: rtl/serial_sub8.sv
// Bit-serial LSB-first subtractor: D = A - B - bin through one full-subtractor cell over WIDTH clocks.
// Optional signed-overflow output ovf is built when SERIAL_SUB_OVF_EN is defined.
module serial_sub8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic [WIDTH-1:0] D,
  output logic             bout,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SUB  = 1'b1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] areg_q, areg_d;
  logic [WIDTH-1:0] breg_q, breg_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             done_q, done_d;

  logic             a_bit, b_bit, diff, borrow_nxt;
  logic [WIDTH-1:0] shifted;

`ifdef SERIAL_SUB_OVF_EN
  logic amsb_q, amsb_d;
  logic bmsb_q, bmsb_d;
  logic ovf_q, ovf_d;
`endif

  // Full-subtractor cell on the current LSBs
  assign a_bit      = areg_q[0];
  assign b_bit      = breg_q[0];
  assign diff       = a_bit ^ b_bit ^ borrow_q;
  assign borrow_nxt = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_q);
  assign shifted    = {diff, res_q};

  always_comb begin
    state_d  = state_q;
    areg_d   = areg_q;
    breg_d   = breg_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    count_d  = count_q;
    d_d      = d_q;
    bout_d   = bout_q;
    done_d   = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    amsb_d   = amsb_q;
    bmsb_d   = bmsb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (load) begin
          areg_d   = A;
          breg_d   = B;
          borrow_d = bin;
          count_d  = '0;
          state_d  = SUB;
`ifdef SERIAL_SUB_OVF_EN
          amsb_d   = A[WIDTH-1];
          bmsb_d   = B[WIDTH-1];
`endif
        end
      end
      default: begin
        areg_d   = areg_q >> 1;
        breg_d   = breg_q >> 1;
        res_d    = shifted[WIDTH-1:1];
        borrow_d = borrow_nxt;
        count_d  = count_q + 1'b1;
        // Last bit: publish the full word and return to IDLE in the same edge
        if (count_q == LAST) begin
          d_d     = shifted;
          bout_d  = borrow_nxt;
          done_d  = 1'b1;
          count_d = '0;
          state_d = IDLE;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (amsb_q != bmsb_q) && (diff != amsb_q);
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      areg_q   <= '0;
      breg_q   <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      count_q  <= '0;
      d_q      <= '0;
      bout_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      amsb_q   <= 1'b0;
      bmsb_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      areg_q   <= areg_d;
      breg_q   <= breg_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      count_q  <= count_d;
      d_q      <= d_d;
      bout_q   <= bout_d;
      done_q   <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      amsb_q   <= amsb_d;
      bmsb_q   <= bmsb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign D    = d_q;
  assign bout = bout_q;
  assign done = done_q;
  assign busy = (state_q == SUB);
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub8.sv
// Directed and random checks of serial_sub8 against an arithmetic reference model.
module tb_serial_sub8;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, load, bin;
  logic [W-1:0] A, B;
  logic [W-1:0] D;
  logic         bout, busy, done;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_d_hold;
  logic         exp_b_hold;

  serial_sub8 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .load(load), .A(A), .B(B), .bin(bin),
    .D(D), .bout(bout), .busy(busy), .done(done)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one active edge and settle on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs one operation; inj_cycle>0 pulses a garbage load at that busy cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bi, input int inj_cycle, input bit chain);
    int exp_full;
    logic [W-1:0] exp_d;
    logic exp_b;
    exp_full = int'(a) - int'(b) - int'(bi);
    exp_d = W'(exp_full);
    exp_b = (exp_full < 0);
    A = a; B = b; bin = bi; load = 1'b1;
    step();
    load = 1'b0;
    chk("busy_start", busy, 1'b1);
    chk("done_start", done, 1'b0);
    for (int i = 1; i < W; i++) begin
      if (i == inj_cycle) begin
        A = '1; B = '0; bin = 1'b1; load = 1'b1;
      end
      step();
      load = 1'b0;
      if (i == W - 1 || i == inj_cycle) begin
        chk("busy_mid", busy, 1'b1);
        chk("done_mid", done, 1'b0);
        chk("d_hold_mid", D, exp_d_hold);
        chk("b_hold_mid", bout, exp_b_hold);
      end
    end
    step();
    chk("done_pulse", done, 1'b1);
    chk("busy_end", busy, 1'b0);
    chk("d_result", D, exp_d);
    chk("bout_result", bout, exp_b);
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf_result", ovf, (a[W-1] != b[W-1]) && (exp_d[W-1] != a[W-1]));
`endif
    exp_d_hold = exp_d;
    exp_b_hold = exp_b;
    if (!chain) begin
      step();
      chk("done_clear", done, 1'b0);
      chk("d_stable", D, exp_d);
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; A = '0; B = '0; bin = 1'b0;
    exp_d_hold = '0; exp_b_hold = 1'b0;
    @(negedge clk);
    step();
    rst = 1'b0;
    chk("rst_d", D, '0);
    chk("rst_bout", bout, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    for (int i = 0; i < 5; i++) step();
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done, 1'b0);
    chk("idle_d", D, '0);

    run_op(8'd13, 8'd38, 1'b0, 0, 1'b0);
    chk("d_e7", D, 8'hE7);
    run_op(8'd38, 8'd13, 1'b0, 0, 1'b0);
    chk("d_25", D, 8'd25);
    run_op(8'h00, 8'h00, 1'b1, 0, 1'b0);
    chk("d_ff", D, 8'hFF);
    run_op(8'h80, 8'h01, 1'b0, 0, 1'b0);
    chk("d_7f", D, 8'h7F);

    // Ignored load while busy, then back-to-back load in the done cycle
    run_op(8'd13, 8'd38, 1'b0, 3, 1'b1);
    chk("ign_d", D, 8'hE7);
    run_op(8'd38, 8'd13, 1'b0, 0, 1'b0);
    chk("b2b_d", D, 8'd25);

    // Reset in mid-operation
    A = 8'd38; B = 8'd13; bin = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_d", D, '0);
    begin
      int done_seen = 0;
      for (int i = 0; i < W + 3; i++) begin
        step();
        if (done) done_seen++;
      end
      chk("mid_rst_nodone", done_seen, 0);
      chk("mid_rst_d_after", D, '0);
    end
    exp_d_hold = '0; exp_b_hold = 1'b0;
    run_op(8'd38, 8'd13, 1'b0, 0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 0, n[0]);
    end
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
